// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults, FSM state encoding
// and the constant width helper used by the TX and RX blocks.
package uart_pkg;

    localparam int DBIT_DEF    = 8;
    localparam int OS_DEF      = 16;
    localparam int SB_TICK_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    // Ceiling log2, never less than 1 so it is usable as a width.
    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_tx_tick.sv
// Oversampling UART transmitter paced by an external s_tick.
// Frame: start bit, DBIT data bits LSB first, SB_TICK-tick stop.
module uart_tx_tick
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int OS      = OS_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int SW = log2((OS > SB_TICK) ? OS : SB_TICK);
    localparam int NW = log2(DBIT);

    localparam logic [SW-1:0] OS_LAST = SW'(OS - 1);
    localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

    uart_state_t     state, state_n;
    logic [SW-1:0]   s, s_n;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] b, b_n;
    logic            tx_n;
    logic            done_n;

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        b_n     = b;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_start) begin
                    state_n = START;
                    s_n     = '0;
                    b_n     = din;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == OS_LAST) begin
                        state_n = DATA;
                        s_n     = '0;
                        n_n     = '0;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == OS_LAST) begin
                        s_n = '0;
                        b_n = b >> 1;
                        if (n == N_LAST) state_n = STOP;
                        else n_n = n + 1'b1;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == SB_LAST) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
        endcase
    end

    // Line level follows the next state so the pin is a plain flop.
    always_comb begin
        tx_n = 1'b1;
        unique case (state_n)
            IDLE:  tx_n = 1'b1;
            START: tx_n = 1'b0;
            DATA:  tx_n = b_n[0];
            STOP:  tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_n;
            s            <= s_n;
            n            <= n_n;
            b            <= b_n;
            tx           <= tx_n;
            tx_done_tick <= done_n;
        end
    end

    assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_tick.sv
// Directed self-checking bench for uart_tx_tick.
// Two instances: SB_TICK=16 and SB_TICK=32.
module tb_uart_tx_tick;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_tick;
    logic       tx_start;
    logic [7:0] din;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;

    int checks   = 0;
    int failures = 0;
    int div      = 1;
    int cyc      = 0;
    logic line [0:4095];

    int da, bn, c1, c2, cnt_b, cnt_d, ones;

    always #5 clk = ~clk;

    uart_tx_tick #(.DBIT(8), .SB_TICK(16), .OS(16)) u_dut0 (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .tx_start     (tx_start),
        .din          (din),
        .tx           (tx0),
        .tx_busy      (busy0),
        .tx_done_tick (done0)
    );

    uart_tx_tick #(.DBIT(8), .SB_TICK(32), .OS(16)) u_dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .tx_start     (tx_start),
        .din          (din),
        .tx           (tx1),
        .tx_busy      (busy1),
        .tx_done_tick (done1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        s_tick = (div != 0) && ((cyc % div) == 0);
    endtask

    task automatic accept(input logic [7:0] d, input bit hold);
        din      = d;
        tx_start = 1'b1;
        step();
        if (!hold) tx_start = 1'b0;
    endtask

    // Records the line from the accept edge until the done pulse.
    task automatic capture(input bit sel, input int inj_t,
                           output int done_at, output int busy_n);
        logic x, b, d;
        done_at = -1;
        busy_n  = 0;
        for (int t = 0; t < 4096; t++) begin
            x = sel ? tx1 : tx0;
            b = sel ? busy1 : busy0;
            d = sel ? done1 : done0;
            line[t] = x;
            if (b) busy_n++;
            if (d) begin
                done_at = t;
                break;
            end
            if (inj_t >= 0 && t == inj_t) begin
                tx_start = 1'b1;
                din      = 8'hFF;
            end else if (inj_t >= 0 && t == inj_t + 1) begin
                tx_start = 1'b0;
            end
            step();
        end
    endtask

    task automatic check_bits(input string tag, input logic [7:0] d,
                              input int bl);
        logic e;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) e = 1'b0;
            else if (i == 9) e = 1'b1;
            else e = d[i-1];
            check($sformatf("%s_bit%0d", tag, i),
                  {31'd0, line[i*bl + bl/2]}, {31'd0, e});
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        s_tick   = 1'b0;
        tx_start = 1'b0;
        din      = 8'h00;
        repeat (3) step();
        check("rst_tx", {31'd0, tx0}, 32'd1);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_tx_sb32", {31'd0, tx1}, 32'd1);
        reset_n = 1'b1;
        step();

        // basic frame, one tick per clk
        accept(8'hA5, 1'b0);
        check("acc_tx", {31'd0, tx0}, 32'd0);
        check("acc_busy", {31'd0, busy0}, 32'd1);
        capture(1'b0, -1, da, bn);
        check("a5_done_at", da, 160);
        check("a5_busy_len", bn, 160);
        check_bits("a5", 8'hA5, 16);
        step();
        check("a5_done_1clk", {31'd0, done0}, 32'd0);
        repeat (40) step();

        // slow ticks; accept lands on a tick that must not count
        div = 4;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_tick) break;
        end
        accept(8'h3C, 1'b0);
        capture(1'b0, -1, da, bn);
        check("slow_done_at", da, 640);
        check_bits("3c", 8'h3C, 64);
        div = 1;
        repeat (100) step();

        // request mid-frame must be ignored
        accept(8'h00, 1'b0);
        capture(1'b0, 40, da, bn);
        check("ign_done_at", da, 160);
        check_bits("ign", 8'h00, 16);
        tx_start = 1'b0;
        cnt_b = 0;
        cnt_d = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (busy0) cnt_b++;
            if (done0) cnt_d++;
        end
        check("ign_no_frame", cnt_b, 0);
        check("ign_no_done", cnt_d, 0);

        // back-to-back with tx_start held
        din      = 8'h55;
        tx_start = 1'b1;
        step();
        din = 8'hAA;
        capture(1'b0, -1, da, bn);
        c1 = cyc;
        check("b2b1_done_at", da, 160);
        check_bits("b2b55", 8'h55, 16);
        step();
        check("b2b_start_tx", {31'd0, tx0}, 32'd0);
        check("b2b_start_busy", {31'd0, busy0}, 32'd1);
        tx_start = 1'b0;
        capture(1'b0, -1, da, bn);
        c2 = cyc;
        check("b2b2_done_at", da, 160);
        check("b2b_gap", c2 - c1, 161);
        check_bits("b2bAA", 8'hAA, 16);
        repeat (200) step();

        // reset during data bit 3
        accept(8'h00, 1'b0);
        repeat (70) step();
        check("pre_rst_tx", {31'd0, tx0}, 32'd0);
        reset_n = 1'b0;
        step();
        check("mid_rst_tx", {31'd0, tx0}, 32'd1);
        check("mid_rst_busy", {31'd0, busy0}, 32'd0);
        check("mid_rst_done", {31'd0, done0}, 32'd0);
        reset_n = 1'b1;
        cnt_d = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done0) cnt_d++;
        end
        check("post_rst_no_done", cnt_d, 0);
        accept(8'h81, 1'b0);
        capture(1'b0, -1, da, bn);
        check("r81_done_at", da, 160);
        check_bits("r81", 8'h81, 16);
        repeat (40) step();

        // two stop bits on the SB_TICK=32 instance
        accept(8'h7F, 1'b0);
        capture(1'b1, -1, da, bn);
        check("sb32_done_at", da, 176);
        check("sb32_busy_len", bn, 176);
        check_bits("sb32", 8'h7F, 16);
        check("sb32_last_data", {31'd0, line[143]}, 32'd0);
        ones = 0;
        for (int t = 144; t < 176; t++) begin
            if (line[t]) ones++;
        end
        check("sb32_stop_len", ones, 32);
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_tick.md
# uart_tx_tick

Oversampling UART transmitter that serializes a parallel word onto a single line, paced by an external one-clock-wide sampling tick (`s_tick`, OS ticks per bit) from the mod-M baud tick generator. It sits between the TX FIFO / host logic and the `tx` pin, and is the transmit counterpart to the tick-driven UART receiver. Frame: 1 start bit (0), DBIT data bits LSB first, stop period of SB_TICK ticks (1).

## Interface
- `DBIT`, 8: data bits per frame; legal range 5–9.
- `SB_TICK`, 16: stop-period length in s_ticks. Use 16, 24 or 32 for 1, 1.5 or 2 stop bits at OS=16.
- `OS`, 16: s_ticks per start/data bit; must be ≥2.

- `clk` input 1: single clock; all state changes on its rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `s_tick` input 1: oversampling enable; one clk wide, asserted once per baud/OS period.
- `tx_start` input 1: request to send `din`; sampled only in IDLE.
- `din` input DBIT: word to send; captured in the cycle `tx_start` is accepted.
- `tx` output 1: serial line, registered. Reset value 1.
- `tx_busy` output 1: 1 in START, DATA or STOP. Reset value 0.
- `tx_done_tick` output 1: one-clk pulse when a frame completes, registered. Reset value 0.

## Operation
- Registers:
  - `state` in {IDLE, START, DATA, STOP}.
  - Tick counter `s`: width log2(max(OS, SB_TICK)).
  - Bit counter `n`: width log2(DBIT).
  - Shift register `b`: DBIT bits.
  - `tx` register and `tx_done_tick` register.
- IDLE: `tx`=1.
  - `tx_start`=1 → capture `din` into `b`, set `s`=0, go to START.
  - Otherwise stay in IDLE. `s_tick` is ignored.
- START: `tx`=0.
  - On `s_tick`: if `s`==OS-1, set `s`=0 and `n`=0 and go to DATA; otherwise increment `s`.
- DATA: `tx`=b[0].
  - On `s_tick` with `s`==OS-1: set `s`=0 and shift `b` right by 1.
  - At that point, if `n`==DBIT-1 go to STOP; otherwise increment `n`.
  - On other `s_tick`s: increment `s`.
- STOP: `tx`=1.
  - On `s_tick`: if `s`==SB_TICK-1, go to IDLE and set `tx_done_tick`=1 on the same edge; otherwise increment `s`.
- `tx` is derived from the next state and updates on the same edge as `state`, so `tx` always matches the current state with no combinational path to the pin.
- Counters never wrap. Each counter is reset to 0 on every state entry that uses it.
- `tx_start` outside IDLE is ignored. There is no queueing, and `din` is not re-sampled.
- `din` changes after acceptance have no effect on the frame in flight.

## Timing
- Reset: `reset_n`=0 at an edge forces IDLE, `tx`=1, `tx_busy`=0, `tx_done_tick`=0, and `s`, `n`, `b` to 0.
  - Mid-frame reset aborts the frame with no done pulse; the line returns to 1 on that edge.
- Accept latency: `tx_start` high at edge k in IDLE → `tx`=0 and `tx_busy`=1 from edge k.
- Duration:
  - Start bit and each data bit last exactly OS s_ticks.
  - Stop period lasts SB_TICK s_ticks.
  - Whole frame: (1+DBIT)·OS + SB_TICK s_ticks.
- `tx_done_tick` is high for exactly one clk: the first IDLE cycle after the frame.
- Back-to-back frames: `tx_start` held high during the `tx_done_tick` cycle is accepted on that cycle. The next start bit begins one clk after STOP ends.
- `s_tick` and `tx_start` in the same IDLE cycle: the start is accepted and that tick is not counted.
- With `s_tick` tied high, the block runs at one tick per clk.

## Structure
- Shared package `uart_pkg` holds:
  - The state enum (IDLE/START/DATA/STOP, 2-bit encoding).
  - The `log2` constant function used for counter widths.
  - Default constants DBIT=8, OS=16, SB_TICK=16, shared with the receiver.
- Single module with no sub-modules. The baud tick generator is instantiated by the parent, not inside this block.

## Test plan
All scenarios use DBIT=8, OS=16, SB_TICK=16.
- Basic frame: `s_tick` every clk, `din`=0xA5, one-clk `tx_start`.
  - `tx` sequence in 16-clk bits: 0, 1,0,1,0,0,1,0,1, then 1 for 16 clks.
  - `tx_done_tick` pulses once, 160 clks after acceptance.
  - `tx_busy` is high for exactly 160 clks.
- Slow ticks: `s_tick` every 4th clk, `din`=0x3C.
  - Each bit lasts 64 clks.
  - `tx_done_tick` comes 640 clks after acceptance.
- Ignored requests: pulse `tx_start` with `din`=0xFF at tick 40 of a 0x00 frame.
  - All data bits stay 0; there is only one done pulse and no second frame.
- Back-to-back: hold `tx_start` high with 0x55 then 0xAA.
  - The second start bit begins exactly 1 clk after the first stop period ends.
  - Two done pulses, 161 clks apart.
- Reset mid-frame: `reset_n`=0 during data bit 3.
  - Next edge: `tx`=1, `tx_busy`=0, no `tx_done_tick`.
  - A new 0x81 frame afterwards transmits correctly.
- Stop length: SB_TICK=32.
  - The stop period is 32 clks high at 1 tick/clk; the frame takes 176 clks total.
